// File: rtl/tdm_demux_16_pkg.sv
// Shared types and default sizes for the TDM demultiplexer and its slot counter.
package tdm_demux_16_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int CHANNELS_DEF = 16;
    localparam int SEL_W_DEF    = 4;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot index counter with clear, load-to-1 and last-slot flag.
// Priority: clr over load1 over inc. Shared with the matching transmitter.
module tdm_slot_ctr #(
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] slot,
    output logic             last
);

    // Slot index register; the natural SEL_W overflow gives the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SEL_W'(1);
        end else if (inc) begin
            slot <= slot + SEL_W'(1);
        end
    end

    assign last = &slot;

endmodule

// File: rtl/tdm_demux_16.sv
// Serial TDM demultiplexer: slot k of a sync-framed bit stream goes to dout[k].
//
// state  | meaning
// HUNT   | waiting for a beat with frame_sync to start a frame
// LOCKED | aligned; every beat is written to shadow[slot]
module tdm_demux_16
    import tdm_demux_16_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int SEL_W    = SEL_W_DEF,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din,
    input  logic                din_valid,
    input  logic                frame_sync,
    output logic [CHANNELS-1:0] dout,
    output logic                frame_valid,
    output logic [SEL_W-1:0]    slot,
    output logic                locked,
    output logic                sync_err,
    output logic [CNT_W-1:0]    frames_ok
);

    state_t              state, state_nxt;
    logic [CHANNELS-1:0] shadow, shadow_nxt;
    logic                ctr_clr, ctr_load1, ctr_inc;
    logic                last_slot;
    logic                complete;
    logic                err;

    tdm_slot_ctr #(
        .SEL_W (SEL_W)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (slot),
        .last  (last_slot)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Framing decisions per beat; idle cycles leave everything untouched.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        ctr_clr    = 1'b0;
        ctr_load1  = 1'b0;
        ctr_inc    = 1'b0;
        complete   = 1'b0;
        err        = 1'b0;
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_nxt[0] = din;
                        ctr_load1     = 1'b1;
                        state_nxt     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (slot != '0)) begin
                        // Early sync: drop the partial frame and restart at slot 0.
                        err           = 1'b1;
                        shadow_nxt    = '0;
                        shadow_nxt[0] = din;
                        ctr_load1     = 1'b1;
                    end else if (!frame_sync && (slot == '0)) begin
                        // Missing sync: lose lock, discard the beat.
                        err       = 1'b1;
                        ctr_clr   = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        shadow_nxt[slot] = din;
                        ctr_inc          = 1'b1;
                        complete         = last_slot;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Shadow, output frame, pulses and good-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            frames_ok   <= '0;
        end else begin
            shadow      <= shadow_nxt;
            frame_valid <= complete;
            sync_err    <= err;
            if (complete) begin
                dout      <= {din, shadow[CHANNELS-2:0]};
                frames_ok <= frames_ok + CNT_W'(1);
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_16.sv
// Directed bench for tdm_demux_16.
module tb_tdm_demux_16;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        din_valid;
    logic        frame_sync;
    logic [15:0] dout;
    logic        frame_valid;
    logic [3:0]  slot;
    logic        locked;
    logic        sync_err;
    logic [7:0]  frames_ok;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int serr_cnt = 0;
    logic [15:0] fv_q[$];
    logic [15:0] rnd_val;

    tdm_demux_16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err),
        .frames_ok   (frames_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every delivered frame and every framing-error pulse.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            fv_q.push_back(dout);
        end
        if (sync_err) serr_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic d, input logic s);
        @(negedge clk);
        din        = d;
        frame_sync = s;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        din        = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] v, input int gap_at);
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                idle(3);
                check("slot_hold", 32'(slot), 32'(i));
            end
            beat(v[i], i == 0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'h0);
        check({tag, "_fv"}, 32'(frame_valid), 32'h0);
        check({tag, "_slot"}, 32'(slot), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_serr"}, 32'(sync_err), 32'h0);
        check({tag, "_fok"}, 32'(frames_ok), 32'h0);
    endtask

    initial begin
        int fv_start;
        int serr_start;
        rst_n      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        #23;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Beats without sync while hunting are ignored.
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        check("hunt_slot", 32'(slot), 32'h0);
        check("hunt_locked", 32'(locked), 32'h0);

        // First frame 0xA5C3.
        for (int i = 0; i < 15; i++) beat(1'(16'hA5C3 >> i), i == 0);
        check("mid_dout", 32'(dout), 32'h0);
        check("mid_fv", 32'(frame_valid), 32'h0);
        check("mid_slot", 32'(slot), 32'd15);
        beat(1'b1, 1'b0);
        check("f1_fv", 32'(frame_valid), 32'h1);
        check("f1_dout", 32'(dout), 32'hA5C3);
        check("f1_fok", 32'(frames_ok), 32'h1);
        check("f1_locked", 32'(locked), 32'h1);
        check("f1_slot", 32'(slot), 32'h0);
        idle(1);
        check("f1_fv_pulse", 32'(frame_valid), 32'h0);
        check("f1_dout_hold", 32'(dout), 32'hA5C3);
        check("f1_serr_cnt", 32'(serr_cnt), 32'h0);

        // Three frames with mid-frame idle gaps.
        fv_q.delete();
        fv_start = fv_cnt;
        send_frame(16'h0001, 5);
        send_frame(16'h8000, 11);
        send_frame(16'hFFFF, 1);
        idle(1);
        check("f3_fv_cnt", 32'(fv_cnt - fv_start), 32'd3);
        check("f3_q0", 32'(fv_q[0]), 32'h0001);
        check("f3_q1", 32'(fv_q[1]), 32'h8000);
        check("f3_q2", 32'(fv_q[2]), 32'hFFFF);
        check("f3_fok", 32'(frames_ok), 32'd4);
        check("f3_serr_cnt", 32'(serr_cnt), 32'h0);

        // Early sync at slot 7 restarts a frame that then completes as 0x1234.
        fv_start = fv_cnt;
        for (int i = 0; i < 7; i++) beat(1'b1, i == 0);
        check("es_pre_slot", 32'(slot), 32'd7);
        beat(1'b0, 1'b1);
        check("es_serr", 32'(sync_err), 32'h1);
        check("es_fv", 32'(frame_valid), 32'h0);
        check("es_slot", 32'(slot), 32'h1);
        check("es_locked", 32'(locked), 32'h1);
        check("es_dout", 32'(dout), 32'hFFFF);
        for (int i = 1; i < 16; i++) beat(1'(16'h1234 >> i), 1'b0);
        check("es_serr_pulse", 32'(sync_err), 32'h0);
        check("es_dout_new", 32'(dout), 32'h1234);
        check("es_fv_new", 32'(frame_valid), 32'h1);
        check("es_fv_cnt", 32'(fv_cnt - fv_start), 32'd0);
        idle(1);
        check("es_fv_total", 32'(fv_cnt - fv_start), 32'd1);
        check("es_fok", 32'(frames_ok), 32'd5);

        // Missing sync at slot 0 drops lock; next sync relocks cleanly.
        beat(1'b1, 1'b0);
        check("ms_serr", 32'(sync_err), 32'h1);
        check("ms_locked", 32'(locked), 32'h0);
        check("ms_slot", 32'(slot), 32'h0);
        check("ms_dout", 32'(dout), 32'h1234);
        check("ms_fv", 32'(frame_valid), 32'h0);
        serr_start = serr_cnt;
        idle(1);
        check("ms_serr_pulse", 32'(sync_err), 32'h0);
        send_frame(16'h0F0F, -1);
        check("rl_dout", 32'(dout), 32'h0F0F);
        check("rl_locked", 32'(locked), 32'h1);
        check("rl_fok", 32'(frames_ok), 32'd6);
        idle(1);
        check("rl_serr_cnt", 32'(serr_cnt - serr_start), 32'd1);

        // Reset mid-frame at slot 9.
        for (int i = 0; i < 9; i++) beat(1'(16'hC3C3 >> i), i == 0);
        check("rm_slot", 32'(slot), 32'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rm");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(16'h5A5A, -1);
        check("rm_dout", 32'(dout), 32'h5A5A);
        check("rm_fok", 32'(frames_ok), 32'd1);

        // 256 good frames wrap the counter back to zero.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fv_start = fv_cnt;
        rnd_val  = 16'h0;
        for (int f = 0; f < 256; f++) begin
            rnd_val = 16'($urandom);
            send_frame(rnd_val, -1);
            if (f == 254) check("wr_fok_255", 32'(frames_ok), 32'd255);
        end
        check("wr_fok_0", 32'(frames_ok), 32'h0);
        check("wr_dout", 32'(dout), 32'(rnd_val));
        idle(1);
        check("wr_fv_cnt", 32'(fv_cnt - fv_start), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
